spi_slave: RTL and testbench

Serial front end of the SPI-slave/single-port-RAM subsystem. Deserialises 10-bit command frames from MOSI, presents each frame to the RAM as a parallel word with a one-cycle `rx_valid` strobe, and on read-data commands serialises the RAM's 8-bit reply back onto MISO. Sits directly upstream of the RAM block and consumes its `tx_valid`/`dout` reply.

---
 rtl/spi_slave.sv | 169 ++++++++++++++++
 tb/tb_spi_slave.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI slave front end: deserialises 10-bit command frames, strobes them to the RAM,
// and shifts RAM read replies out on MISO. Optional abort flag: SPI_SLAVE_ABORT_FLAG_EN.
module spi_slave #(
  parameter int FRAME_W = 10,
  parameter int DATA_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ss_n,
  input  logic               mosi,
  output logic               miso,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid
`ifdef SPI_SLAVE_ABORT_FLAG_EN
  ,
  output logic               frame_abort
`endif
);

  localparam int CNT_W = $clog2(FRAME_W - 1);
  localparam int TXC_W = $clog2(DATA_W);

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-2:0] shreg_q, shreg_d;
  logic [FRAME_W-1:0] rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               rd_addr_seen_q, rd_addr_seen_d;
  logic               rx_done_q, rx_done_d;
  logic               frame_done_q, frame_done_d;
  logic               tx_active_q, tx_active_d;
  logic [TXC_W-1:0]   tx_left_q, tx_left_d;
  logic [DATA_W-2:0]  tx_sh_q, tx_sh_d;
  logic               miso_q, miso_d;
`ifdef SPI_SLAVE_ABORT_FLAG_EN
  logic               abort_q, abort_d;
`endif

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shreg_d        = shreg_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rd_addr_seen_d = rd_addr_seen_q;
    rx_done_d      = rx_done_q;
    frame_done_d   = frame_done_q;
    tx_active_d    = tx_active_q;
    tx_left_d      = tx_left_q;
    tx_sh_d        = tx_sh_q;
    miso_d         = miso_q;
`ifdef SPI_SLAVE_ABORT_FLAG_EN
    abort_d        = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!ss_n) state_d = CHK_CMD;
      end
      CHK_CMD: begin
        shreg_d   = {shreg_q[FRAME_W-3:0], mosi};
        bit_cnt_d = '0;
        if (!mosi)               state_d = WRITE;
        else if (rd_addr_seen_q) state_d = READ_DATA;
        else                     state_d = READ_ADD;
      end
      default: begin
        if (!rx_done_q) begin
          shreg_d   = {shreg_q[FRAME_W-3:0], mosi};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == CNT_W'(FRAME_W - 2)) begin
            rx_data_d  = {shreg_q, mosi};
            rx_valid_d = 1'b1;
            rx_done_d  = 1'b1;
            if (state_q != READ_DATA) frame_done_d = 1'b1;
            if (state_q == READ_ADD)  rd_addr_seen_d = 1'b1;
          end
        end else if (state_q == READ_DATA) begin
          if (!tx_active_q && !frame_done_q) begin
            if (tx_valid) begin
              miso_d      = tx_data[DATA_W-1];
              tx_sh_d     = tx_data[DATA_W-2:0];
              tx_left_d   = TXC_W'(DATA_W - 1);
              tx_active_d = 1'b1;
            end
          end else if (tx_active_q) begin
            if (tx_left_q != '0) begin
              miso_d    = tx_sh_q[DATA_W-2];
              tx_sh_d   = {tx_sh_q[DATA_W-3:0], 1'b0};
              tx_left_d = tx_left_q - 1'b1;
              // Frame counts as complete once the last reply bit is on the line.
              if (tx_left_q == TXC_W'(1)) begin
                frame_done_d   = 1'b1;
                rd_addr_seen_d = 1'b0;
              end
            end else begin
              miso_d      = 1'b0;
              tx_active_d = 1'b0;
            end
          end
        end
      end
    endcase

    // Deselect overrides everything; an unfinished frame leaves no trace.
    if (ss_n && state_q != IDLE) begin
      state_d        = IDLE;
      bit_cnt_d      = '0;
      rx_data_d      = rx_data_q;
      rx_valid_d     = 1'b0;
      rd_addr_seen_d = rd_addr_seen_q;
      rx_done_d      = 1'b0;
      frame_done_d   = 1'b0;
      tx_active_d    = 1'b0;
      tx_left_d      = '0;
      miso_d         = 1'b0;
`ifdef SPI_SLAVE_ABORT_FLAG_EN
      abort_d        = !frame_done_q;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      shreg_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_seen_q <= 1'b0;
      rx_done_q      <= 1'b0;
      frame_done_q   <= 1'b0;
      tx_active_q    <= 1'b0;
      tx_left_q      <= '0;
      tx_sh_q        <= '0;
      miso_q         <= 1'b0;
`ifdef SPI_SLAVE_ABORT_FLAG_EN
      abort_q        <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shreg_q        <= shreg_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rd_addr_seen_q <= rd_addr_seen_d;
      rx_done_q      <= rx_done_d;
      frame_done_q   <= frame_done_d;
      tx_active_q    <= tx_active_d;
      tx_left_q      <= tx_left_d;
      tx_sh_q        <= tx_sh_d;
      miso_q         <= miso_d;
`ifdef SPI_SLAVE_ABORT_FLAG_EN
      abort_q        <= abort_d;
`endif
    end
  end

  assign miso     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
`ifdef SPI_SLAVE_ABORT_FLAG_EN
  assign frame_abort = abort_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a frame-level timing model predicts every output each
// cycle; literal expectations pin the model on key frames.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ss_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
`ifdef SPI_SLAVE_ABORT_FLAG_EN
  logic       frame_abort;
`endif

  spi_slave #(.FRAME_W(10), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .ss_n(ss_n), .mosi(mosi), .miso(miso),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid)
`ifdef SPI_SLAVE_ABORT_FLAG_EN
    , .frame_abort(frame_abort)
`endif
  );

  always #5 clk = ~clk;

  int unsigned total  = 0;
  int unsigned passed = 0;

  logic       exp_miso = 1'b0;
  logic       exp_rx_valid = 1'b0;
  logic [9:0] exp_rx_data = '0;
  logic       exp_abort = 1'b0;
  bit         chk_en = 1'b0;
  bit         model_flag = 1'b0;
  logic [7:0] cap_byte;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("miso", {31'd0, miso}, {31'd0, exp_miso});
      chk("rx_valid", {31'd0, rx_valid}, {31'd0, exp_rx_valid});
      chk("rx_data", {22'd0, rx_data}, {22'd0, exp_rx_data});
`ifdef SPI_SLAVE_ABORT_FLAG_EN
      chk("frame_abort", {31'd0, frame_abort}, {31'd0, exp_abort});
`endif
    end
  end

  // One frame: ss_n low for edges 0..L-1, high at edge L. t_cyc = edge at which
  // tx_valid is offered with txd; spur_cyc offers tx_valid with 0xFF; rst_cyc resets mid-frame.
  task automatic run_frame(input logic [9:0] frame, input int L, input int t_cyc,
                           input logic [7:0] txd, input int spur_cyc, input int rst_cyc);
    bit rd_data_kind, rd_add_kind, tx_ok, complete, in_tx;
    rd_data_kind = frame[9] && model_flag;
    rd_add_kind  = frame[9] && !model_flag;
    tx_ok        = rd_data_kind && t_cyc >= 11 && t_cyc < L;
    complete     = rd_data_kind ? (tx_ok && t_cyc + 7 < L) : (L > 10);
    cap_byte     = '0;
    for (int n = 0; n <= L; n++) begin
      ss_n     = (n < L) ? 1'b0 : 1'b1;
      mosi     = (n >= 1 && n <= 10) ? frame[10-n] : 1'($urandom_range(0, 1));
      tx_valid = (n == t_cyc || n == spur_cyc);
      tx_data  = (n == spur_cyc) ? 8'hFF : txd;
      @(posedge clk);
      #1;
      in_tx        = tx_ok && n >= t_cyc && n <= t_cyc + 7 && n < L;
      exp_rx_valid = (n == 10 && L > 10);
      if (exp_rx_valid) exp_rx_data = frame;
      exp_miso     = in_tx ? txd[7-(n-t_cyc)] : 1'b0;
      exp_abort    = (n == L) && !complete;
      if (in_tx) cap_byte = {cap_byte[6:0], miso};
      if (n == rst_cyc) begin
        #2 rst = 1'b1;
        #1;
        chk("rst_miso", {31'd0, miso}, 32'd0);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_rx_data", {22'd0, rx_data}, 32'd0);
        chk_en   = 1'b0;
        ss_n     = 1'b1;
        tx_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_miso = 1'b0; exp_rx_valid = 1'b0; exp_rx_data = '0; exp_abort = 1'b0;
        model_flag = 1'b0;
        chk_en = 1'b1;
        return;
      end
    end
    tx_valid = 1'b0;
    if (complete && rd_add_kind)  model_flag = 1'b1;
    if (complete && rd_data_kind) model_flag = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_miso", {31'd0, miso}, 32'd0);
    chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("reset_rx_data", {22'd0, rx_data}, 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Write pair, second with spurious tx_valid; then one write with trailing junk bits.
    run_frame(10'b00_1010_0101, 12, -1, 8'h00, -1, -1);
    chk("wr1_literal", {22'd0, rx_data}, 32'h0A5);
    run_frame(10'b01_0011_1100, 12, -1, 8'h00, 12, -1);
    chk("wr2_literal", {22'd0, rx_data}, 32'h13C);
    run_frame(10'b00_0110_1001, 14, -1, 8'h00, 5, -1);

    // Read address then read data with reply 0xC3 at cycle 12.
    run_frame(10'b10_0000_0111, 12, -1, 8'h00, -1, -1);
    run_frame(10'b11_0000_0000, 21, 12, 8'hC3, -1, -1);
    chk("rd_c3_literal", {24'd0, cap_byte}, 32'h0C3);

    // Flag now clear: an 11-frame is a read address, tx_valid ignored.
    run_frame(10'b11_0000_0000, 12, 12, 8'hAA, -1, -1);
    chk("rdadd_literal", {22'd0, rx_data}, 32'h300);
    run_frame(10'b11_0101_0101, 21, 13, 8'h5A, -1, -1);
    chk("rd_5a_literal", {24'd0, cap_byte}, 32'h05A);

    // Abort after 5 bits, then a clean frame; flag must be unchanged by the abort.
    run_frame(10'b11_1111_1111, 6, -1, 8'h00, -1, -1);
    run_frame(10'b00_1111_1111, 12, -1, 8'h00, -1, -1);
    chk("after_abort_literal", {22'd0, rx_data}, 32'h0FF);
    run_frame(10'b10_0000_0000, 12, 12, 8'h81, -1, -1);

    // Reset during a reply, then the next frame decodes normally.
    run_frame(10'b10_0000_0001, 12, -1, 8'h00, -1, -1);
    run_frame(10'b11_1110_0000, 21, 12, 8'hF0, -1, 14);
    run_frame(10'b01_0101_0101, 12, -1, 8'h00, -1, -1);
    chk("post_rst_literal", {22'd0, rx_data}, 32'h155);
    run_frame(10'b10_1100_1100, 12, -1, 8'h00, -1, -1);
    run_frame(10'b11_1100_1100, 20, 12, 8'h96, -1, -1);
    chk("rd_96_literal", {24'd0, cap_byte}, 32'h096);

    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
